// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: one-outstanding request/ack fetcher feeding a show-ahead PC/instruction queue.
// Optional counters fetch_stall_cnt/flush_cnt are built when FETCH_PERF_EN is defined.
module fetch_queue_unit #(
   parameter int ADDR_W   = 16,
   parameter int INSTR_W  = 16,
   parameter int DEPTH    = 4,
   parameter int PC_STEP  = 2,
   parameter int RESET_PC = 0
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   input  logic               hlt,
   output logic               dec_valid,
   output logic [INSTR_W-1:0] dec_instr,
   output logic [ADDR_W-1:0]  dec_pc,
   input  logic               dec_ready,
   output logic [ADDR_W-1:0]  pc,
   output logic               halted,
   output logic [1:0]         dbg_state
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]        fetch_stall_cnt,
   output logic [15:0]        flush_cnt
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   // Handshakes: imem_req/imem_addr are held until the cycle imem_ack is seen (one outstanding);
   // a queue entry transfers to decode on any rising edge where dec_valid && dec_ready.
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN, S_HALT} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d, addr_q;
   logic                start_req, push, pop;
   logic [PTR_W-1:0]    wr_q, rd_q;
   logic [CNT_W-1:0]    count_q;
   logic [ADDR_W-1:0]   pc_mem    [DEPTH];
   logic [INSTR_W-1:0]  instr_mem [DEPTH];

   always_comb begin
      state_d   = state_q;
      start_req = 1'b0;
      push      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (hlt) begin
               state_d = S_HALT;
            end else if (!redirect && (count_q < CNT_W'(DEPTH))) begin
               state_d   = S_REQ;
               start_req = 1'b1;
            end
         end
         S_REQ: begin
            if (imem_ack) begin
               push    = !redirect;
               state_d = hlt ? S_HALT : S_IDLE;
            end else if (redirect) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (imem_ack) state_d = hlt ? S_HALT : S_IDLE;
         end
         S_HALT: begin
            if (!hlt) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A redirect retargets pc immediately; an in-flight fetch keeps its own address in addr_q.
   always_comb begin
      pc_d = pc_q;
      if (redirect)  pc_d = redirect_pc;
      else if (push) pc_d = pc_q + ADDR_W'(PC_STEP);
   end

   assign pop = (count_q != '0) && dec_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pc_q    <= ADDR_W'(RESET_PC);
         addr_q  <= ADDR_W'(RESET_PC);
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         if (start_req) addr_q <= pc_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else if (redirect) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_q <= wr_q + PTR_W'(1);
         if (pop)  rd_q <= rd_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_q]    <= pc_q;
         instr_mem[wr_q] <= imem_data;
      end
   end

   assign imem_req  = (state_q == S_REQ) || (state_q == S_DRAIN);
   assign imem_addr = addr_q;
   assign dec_valid = (count_q != '0);
   assign dec_instr = instr_mem[rd_q];
   assign dec_pc    = pc_mem[rd_q];
   assign pc        = pc_q;
   assign halted    = (state_q == S_HALT);
   assign dbg_state = state_q;

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_stall_cnt <= '0;
         flush_cnt       <= '0;
      end else begin
         if (dec_ready && !dec_valid && (state_q != S_HALT) && (fetch_stall_cnt != '1))
            fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
         if (redirect && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: behavioural memory with variable ack latency plus a decode monitor.
module tb_fetch_queue_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req, imem_ack;
   logic [15:0] imem_addr, imem_data;
   logic        redirect, hlt, dec_ready;
   logic [15:0] redirect_pc;
   logic        dec_valid, halted;
   logic [15:0] dec_instr, dec_pc, pc;
   logic [1:0]  dbg_state;
`ifdef FETCH_PERF_EN
   logic [31:0] fetch_stall_cnt;
   logic [15:0] flush_cnt;
`endif

   int pass_cnt = 0;
   int total_cnt = 0;
   int lat = 1;
   int wait_cnt = 0;
   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];
   logic [15:0] req_log[$];

   fetch_queue_unit dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_data(imem_data), .redirect(redirect),
      .redirect_pc(redirect_pc), .hlt(hlt), .dec_valid(dec_valid),
      .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_ready(dec_ready), .pc(pc),
      .halted(halted), .dbg_state(dbg_state)
`ifdef FETCH_PERF_EN
      , .fetch_stall_cnt(fetch_stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_f(input logic [15:0] a);
      logic [15:0] t;
      t = (a << 11) + 16'h1000;
      return t ^ (a & 16'hFFF0);
   endfunction

   // Memory: acks `lat` cycles after the request is first seen, one cycle wide.
   initial begin
      imem_ack  = 1'b0;
      imem_data = '0;
      forever begin
         @(posedge clk); #1;
         if (!rst_n) begin
            imem_ack = 1'b0;
            wait_cnt = 0;
         end else if (imem_ack) begin
            imem_ack = 1'b0;
         end else if (imem_req) begin
            wait_cnt++;
            if (wait_cnt >= lat) begin
               imem_ack  = 1'b1;
               imem_data = mem_f(imem_addr);
               req_log.push_back(imem_addr);
               wait_cnt  = 0;
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && dec_valid && dec_ready) got_q.push_back({dec_pc, dec_instr});
      end
   end

   task automatic tick;
      @(posedge clk); #2;
   endtask

   task automatic apply_reset(input logic h, input logic r);
      #1 rst_n = 1'b0;
      hlt = h; dec_ready = r; redirect = 1'b0; redirect_pc = '0; lat = 1;
      tick; tick;
      exp_q.delete(); got_q.delete(); req_log.delete();
      rst_n = 1'b1;
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (!imem_req && n < 50) begin tick; n++; end
      if (!imem_req) begin total_cnt++; $display("FAIL %s: timeout waiting for imem_req", tag); end
   endtask

   task automatic wait_got(input int cnt, input string tag);
      int n = 0;
      while (got_q.size() < cnt && n < 100) begin tick; n++; end
      if (got_q.size() < cnt) begin total_cnt++; $display("FAIL %s: timeout, %0d of %0d delivered", tag, got_q.size(), cnt); end
   endtask

   task automatic cmp_delivered(input string tag);
      logic [31:0] e, g;
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         total_cnt++;
         if (got_q.size() == 0) $display("FAIL %s: missing delivery, want %h", tag, e);
         else begin
            g = got_q.pop_front();
            if (g !== e) $display("FAIL %s: got {pc,instr}=%h want %h", tag, g, e); else pass_cnt++;
         end
      end
   endtask

   task automatic test_reset;
      hlt = 1'b0; dec_ready = 1'b1; redirect = 1'b0; redirect_pc = '0;
      tick; tick;
      total_cnt++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else pass_cnt++;
      total_cnt++; if (dec_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", dec_valid); else pass_cnt++;
      total_cnt++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else pass_cnt++;
      total_cnt++; if (pc !== 16'h0000) $display("FAIL reset_pc: got %h want 0000", pc); else pass_cnt++;
      total_cnt++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", dbg_state); else pass_cnt++;
   endtask

   task automatic test_sequential;
      logic [15:0] exp_addr [3];
      exp_addr = '{16'h0000, 16'h0002, 16'h0004};
      apply_reset(1'b0, 1'b1);
      exp_q.push_back(32'h0000_1000);
      exp_q.push_back(32'h0002_2000);
      exp_q.push_back(32'h0004_3000);
      wait_got(3, "seq");
      for (int i = 0; i < 3; i++) begin
         total_cnt++;
         if (req_log.size() <= i) $display("FAIL seq_addr%0d: missing request, want %h", i, exp_addr[i]);
         else if (req_log[i] !== exp_addr[i]) $display("FAIL seq_addr%0d: got %h want %h", i, req_log[i], exp_addr[i]);
         else pass_cnt++;
      end
      cmp_delivered("seq_data");
   endtask

   task automatic test_full;
      apply_reset(1'b0, 1'b0);
      repeat (20) tick;
      total_cnt++; if (req_log.size() != 4) $display("FAIL full_reqs: got %0d want 4", req_log.size()); else pass_cnt++;
      total_cnt++; if (imem_req !== 1'b0) $display("FAIL full_req_idle: got %b want 0", imem_req); else pass_cnt++;
      total_cnt++; if ({dec_pc, dec_instr} !== 32'h0000_1000) $display("FAIL full_head: got %h want 00001000", {dec_pc, dec_instr}); else pass_cnt++;
      exp_q.push_back(32'h0000_1000);
      dec_ready = 1'b1;
      tick;
      dec_ready = 1'b0;
      repeat (10) tick;
      total_cnt++; if (req_log.size() != 5) $display("FAIL full_refill: got %0d requests want 5", req_log.size()); else pass_cnt++;
      total_cnt++;
      if (req_log.size() < 5) $display("FAIL full_addr: missing 5th request, want 0008");
      else if (req_log[4] !== 16'h0008) $display("FAIL full_addr: got %h want 0008", req_log[4]);
      else pass_cnt++;
      total_cnt++; if (imem_req !== 1'b0) $display("FAIL full_req_stop: got %b want 0", imem_req); else pass_cnt++;
      total_cnt++; if (dec_pc !== 16'h0002) $display("FAIL full_new_head: got %h want 0002", dec_pc); else pass_cnt++;
      cmp_delivered("full_pop");
      total_cnt++; if (got_q.size() != 0) $display("FAIL full_extra_pop: got %0d extra want 0", got_q.size()); else pass_cnt++;
   endtask

   task automatic test_redirect_drain;
      int n = 0;
      apply_reset(1'b0, 1'b0);
      while (req_log.size() < 3 && n < 50) begin tick; n++; end
      lat = 3;
      tick;
      wait_req("drain");
      total_cnt++; if (imem_addr !== 16'h0006) $display("FAIL drain_addr: got %h want 0006", imem_addr); else pass_cnt++;
      total_cnt++; if (dec_valid !== 1'b1) $display("FAIL drain_prefill: got %b want 1", dec_valid); else pass_cnt++;
      redirect = 1'b1; redirect_pc = 16'h0040;
      tick;
      redirect = 1'b0;
      total_cnt++; if (dec_valid !== 1'b0) $display("FAIL drain_flush: got %b want 0", dec_valid); else pass_cnt++;
      total_cnt++; if ({imem_req, imem_addr} !== {1'b1, 16'h0006}) $display("FAIL drain_hold1: got req=%b addr=%h want 1/0006", imem_req, imem_addr); else pass_cnt++;
      tick;
      total_cnt++; if ({imem_req, imem_addr} !== {1'b1, 16'h0006}) $display("FAIL drain_hold2: got req=%b addr=%h want 1/0006", imem_req, imem_addr); else pass_cnt++;
      lat = 1; dec_ready = 1'b1;
      exp_q.push_back({16'h0040, mem_f(16'h0040)});
      wait_got(1, "drain");
      total_cnt++;
      if (req_log.size() < 5) $display("FAIL drain_next_req: got %0d requests want 5", req_log.size());
      else if (req_log[4] !== 16'h0040) $display("FAIL drain_next_req: got %h want 0040", req_log[4]);
      else pass_cnt++;
      cmp_delivered("drain_data");
   endtask

   task automatic test_redirect_ack;
      apply_reset(1'b0, 1'b1);
      wait_req("rack");
      redirect = 1'b1; redirect_pc = 16'h0080;
      tick;
      redirect = 1'b0;
      total_cnt++; if (dec_valid !== 1'b0) $display("FAIL rack_dropped: got %b want 0", dec_valid); else pass_cnt++;
      total_cnt++; if (pc !== 16'h0080) $display("FAIL rack_pc: got %h want 0080", pc); else pass_cnt++;
      exp_q.push_back({16'h0080, mem_f(16'h0080)});
      wait_got(1, "rack");
      total_cnt++;
      if (req_log.size() < 2) $display("FAIL rack_next_req: got %0d requests want 2", req_log.size());
      else if (req_log[1] !== 16'h0080) $display("FAIL rack_next_req: got %h want 0080", req_log[1]);
      else pass_cnt++;
      cmp_delivered("rack_data");
   endtask

   task automatic test_halt;
      int n = 0;
      bit seen_req = 1'b0;
      apply_reset(1'b0, 1'b1);
      lat = 3;
      wait_req("halt");
      hlt = 1'b1;
      while (!imem_ack && n < 20) begin tick; n++; end
      total_cnt++; if (halted !== 1'b0) $display("FAIL halt_early: got %b want 0", halted); else pass_cnt++;
      tick;
      total_cnt++; if (halted !== 1'b1) $display("FAIL halt_set: got %b want 1", halted); else pass_cnt++;
      total_cnt++; if (dbg_state !== 2'd3) $display("FAIL halt_state: got %0d want 3", dbg_state); else pass_cnt++;
      total_cnt++; if (dec_valid !== 1'b1) $display("FAIL halt_queued: got %b want 1", dec_valid); else pass_cnt++;
      exp_q.push_back(32'h0000_1000);
      repeat (8) begin tick; if (imem_req) seen_req = 1'b1; end
      total_cnt++; if (seen_req !== 1'b0) $display("FAIL halt_no_req: got %b want 0", seen_req); else pass_cnt++;
      total_cnt++; if (pc !== 16'h0002) $display("FAIL halt_pc: got %h want 0002", pc); else pass_cnt++;
      cmp_delivered("halt_data");
      hlt = 1'b0;
      wait_req("resume");
      total_cnt++; if (imem_addr !== 16'h0002) $display("FAIL resume_addr: got %h want 0002", imem_addr); else pass_cnt++;
   endtask

   task automatic test_wrap_reset;
      int n = 0;
      apply_reset(1'b1, 1'b0);
      tick; tick;
      redirect = 1'b1; redirect_pc = 16'hFFFE;
      tick;
      redirect = 1'b0;
      total_cnt++; if (halted !== 1'b1) $display("FAIL wrap_halt_stay: got %b want 1", halted); else pass_cnt++;
      total_cnt++; if (pc !== 16'hFFFE) $display("FAIL wrap_halt_pc: got %h want fffe", pc); else pass_cnt++;
      hlt = 1'b0;
      wait_req("wrap");
      total_cnt++; if (imem_addr !== 16'hFFFE) $display("FAIL wrap_addr: got %h want fffe", imem_addr); else pass_cnt++;
      tick;
      total_cnt++; if (pc !== 16'h0000) $display("FAIL wrap_pc: got %h want 0000", pc); else pass_cnt++;
      total_cnt++; if ({dec_pc, dec_instr} !== {16'hFFFE, 16'hFFF0}) $display("FAIL wrap_head: got %h want fffefff0", {dec_pc, dec_instr}); else pass_cnt++;
      while (!(imem_req && imem_addr == 16'h0002) && n < 50) begin tick; n++; end
      total_cnt++; if (pc !== 16'h0002) $display("FAIL wrap_pre_rst_pc: got %h want 0002", pc); else pass_cnt++;
      #1 rst_n = 1'b0;
      #1;
      total_cnt++; if (imem_req !== 1'b0) $display("FAIL arst_req: got %b want 0", imem_req); else pass_cnt++;
      total_cnt++; if (dec_valid !== 1'b0) $display("FAIL arst_valid: got %b want 0", dec_valid); else pass_cnt++;
      total_cnt++; if (pc !== 16'h0000) $display("FAIL arst_pc: got %h want 0000", pc); else pass_cnt++;
      apply_reset(1'b1, 1'b0);
      tick; tick; tick;
      total_cnt++; if (halted !== 1'b1) $display("FAIL arst_pre_halt: got %b want 1", halted); else pass_cnt++;
      #1 rst_n = 1'b0;
      #1;
      total_cnt++; if (halted !== 1'b0) $display("FAIL arst_halted: got %b want 0", halted); else pass_cnt++;
      tick;
      rst_n = 1'b1;
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_full();
      test_redirect_drain();
      test_redirect_ack();
      test_halt();
      test_wrap_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation CPU.
- Replaces the direct PC-register to instruction-memory path with a request/acknowledge memory interface that tolerates multi-cycle latency.
- Buffers fetched instructions, with their PCs, in a DEPTH-entry show-ahead queue feeding decode through a valid/ready handshake.
- Handles branch redirects (queue flush and stale-response discard) and halt.

Parameters:
ADDR_W, 16, PC and memory address width
INSTR_W, 16, instruction width
DEPTH, 4, queue entries; power of two, at least 2
PC_STEP, 2, byte increment between sequential fetches
RESET_PC, 0, fetch PC after reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  fetch request; held high until imem_ack
imem_addr  out  ADDR_W  fetch address; stable while imem_req is high
imem_ack  in  1  response valid; at most one outstanding request
imem_data  in  INSTR_W  instruction, valid with imem_ack
redirect  in  1  branch/jump taken; one-cycle pulse
redirect_pc  in  ADDR_W  redirect target
hlt  in  1  level; stop issuing new fetches
dec_valid  out  1  queue head valid
dec_instr  out  INSTR_W  head instruction
dec_pc  out  ADDR_W  head PC
dec_ready  in  1  decode accepts head
pc  out  ADDR_W  next fetch PC
halted  out  1  hlt high and no request outstanding

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low on rst_n.
- Reset values: pc=RESET_PC; queue empty; imem_req=0; dec_valid=0; halted=0; state IDLE.
- States:
  - IDLE: no request outstanding.
  - REQ: request outstanding, response to be kept.
  - DRAIN: request outstanding, response to be discarded.
  - HALT: hlt high, nothing outstanding.
- Transitions:
  - IDLE to REQ when hlt=0, redirect=0, and count < DEPTH. imem_req and imem_addr=pc are registered, so the first request appears on the first edge after reset release.
  - REQ on imem_ack:
    - push {pc, imem_data}; pc <= pc+PC_STEP, modulo 2^ADDR_W (wraps 0xFFFE to 0x0000 at defaults);
    - drop imem_req for exactly one cycle, then return to IDLE rules. Sustained throughput is 1 instruction per 2 cycles with a 1-cycle ack.
  - REQ with redirect and no ack: go to DRAIN and keep imem_req and imem_addr unchanged until ack. The ack'd data is discarded and no push occurs. Then go to IDLE with pc=redirect_pc.
  - Redirect coinciding with ack: data discarded; pc <= redirect_pc; go to IDLE.
  - hlt=1 in IDLE: go to HALT and set halted=1.
  - hlt=1 in REQ or DRAIN: the outstanding request completes normally (a REQ ack is pushed), then go to HALT.
  - hlt=0 in HALT: go to IDLE.
- Redirect:
  - flushes the queue the same cycle; dec_valid=0 the following cycle;
  - has priority over push;
  - a pop coinciding with redirect completes (the head is consumed);
  - redirect in HALT updates pc and flushes; the unit stays in HALT.
- Queue:
  - show-ahead: dec_valid = count != 0; dec_instr and dec_pc come from the head;
  - pop when dec_valid & dec_ready;
  - simultaneous push and pop keeps count unchanged;
  - a request is issued only when count < DEPTH, so a push never overflows;
  - a pop on empty is ignored.
- Decode may keep draining the queue while halted.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: adds output port fetch_stall_cnt[31:0], reset to 0.
  - Increments, saturating, each cycle with dec_ready=1, dec_valid=0, and state not HALT.
  - Also adds output port flush_cnt[15:0], which increments, saturating, per redirect.
- Undefined: neither port exists and no counter logic is present.

Test Plan:
- Reset, then memory acks 1 cycle after each request returning 0x1000, 0x2000, 0x3000; dec_ready=1:
  - imem_addr sequence is 0x0000, 0x0002, 0x0004;
  - decode sees {0x0000,0x1000}, {0x0002,0x2000}, {0x0004,0x3000} in order.
- dec_ready=0, DEPTH=4, ack latency 1:
  - exactly 4 requests issued, then imem_req stays 0;
  - one pop triggers exactly one new request at the next address, 0x0008.
- Redirect to 0x0040 while a 3-cycle-latency request to 0x0006 is outstanding:
  - imem_addr holds 0x0006 until ack; that data is dropped;
  - queue flushed; next request is to 0x0040; dec_pc of the next delivered instruction is 0x0040.
- Redirect in the same cycle as ack: that data is not queued; the next request is to redirect_pc.
- Raise hlt mid-request:
  - the request completes and is queued;
  - halted=1 the cycle after the ack; no further imem_req;
  - lower hlt: fetching resumes at the next sequential PC.
- Wrap and reset:
  - pc=0xFFFE then ack: pc becomes 0x0000.
  - assert rst_n=0 mid-request: imem_req, dec_valid, and halted drop immediately (no clock edge); pc=RESET_PC.
